step_controller: RTL
====================

# step_controller

Consumes the one-cycle `tick` from the board clock divider and turns it into the CPU advance enable `cpu_en`. It supports a free-running mode (one enable every `RUN_DIV` ticks) and a single-step mode driven by a debounced push-button. It sits between the divider and the pipeline's global stall/enable input on the FPGA top level.

## Interface
- `DEB_SAMPLES`, default 4: consecutive tick-rate samples required to change the debounced button level; range 2..8.
- `RUN_DIV`, default 1: ticks per `cpu_en` pulse in RUN; range 1..255.
- `CNT_W`, default 16: width of `step_count`.

Ports:
- `clock_in`  in  1: system clock; all logic on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `tick_in`  in  1: one-cycle pulse from the clock divider; arbitrary spacing ≥1 cycle.
- `btn_step`  in  1: raw asynchronous step push-button, active-high.
- `sw_run`  in  1: raw asynchronous run switch, 1 = run.
- `halt_in`  in  1: CPU halted (synchronous to `clock_in`), level.
- `cpu_en`  out  1: one-cycle CPU advance enable, registered.
- `state_out`  out  2: FSM state: IDLE=0, RUN=1, STEP=2, HALTED=3.
- `step_count`  out  `CNT_W`: number of `cpu_en` pulses issued since reset; wraps modulo 2^`CNT_W`.

## Operation
- Reset values: `cpu_en`=0, `state_out`=IDLE, `step_count`=0, synchronizer and debounce registers all 0, run-divide counter 0.
- `btn_step` and `sw_run` each pass through a 2-FF synchronizer. `sw_run` is not debounced; `run` means the synchronized value.
- Debounce: on each `tick_in`, shift the synchronized button into a `DEB_SAMPLES`-bit register.
  - `btn_db` goes to 1 when the register is all-ones and to 0 when it is all-zeros; otherwise it holds.
  - `step_req` is a one-cycle pulse on the 0→1 transition of `btn_db`.
- FSM, with priority top to bottom in every state:
  - Any state, `halt_in`=1 → HALTED. No `cpu_en` is issued in that cycle.
  - IDLE: `run`=1 → RUN, with the divide counter cleared. Else `step_req` → STEP. Else stay.
  - RUN: `run`=0 → IDLE, with no pulse even if `tick_in` is high. On `tick_in`, the divide counter increments. When it reaches `RUN_DIV`-1, it clears and `cpu_en` is asserted the next cycle. `step_req` is ignored.
  - STEP: `cpu_en`=1 for exactly this cycle's registered output, then go to IDLE.
  - HALTED: `cpu_en`=0. `halt_in`=0 → IDLE.
- `step_count` increments in the cycle after each `cpu_en`=1, and wraps from all-ones to 0.
- `cpu_en` is never high in two consecutive cycles when `RUN_DIV`=1 and ticks are ≥2 cycles apart. Each issued pulse is exactly one cycle wide.

## Timing
- RUN latency: `tick_in` high in cycle N → `cpu_en` high in cycle N+1. This holds with `RUN_DIV`=1 and counter at terminal.
- Step latency: the `DEB_SAMPLES`-th consecutive high tick sample in cycle N gives `step_req` at N+1, STEP at N+2, and `cpu_en` at N+2.
- Input synchronizers add 2 cycles before a sample is visible to the debounce or FSM.
- `halt_in` asserted in cycle N gives `state_out`=HALTED in N+1. A pending RUN pulse for cycle N+1 is suppressed.
- `reset_n` asserted mid-pulse drops `cpu_en` to 0 immediately (asynchronous).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `step_ctrl_pkg` holds:
  - the state encoding constants IDLE/RUN/STEP/HALTED (2-bit);
  - `STATE_W`=2.
- One sub-module, `debounce_tick`: synchronizer, tick-sampled shift register, and level/edge outputs (`btn_db`, `step_req`). Parameterized by `DEB_SAMPLES`.
- The top module holds the FSM, the divide counter, and `step_count`.

## Test plan
- Reset: `reset_n`=0 for 3 cycles, then release → `cpu_en`=0, `state_out`=0, `step_count`=0 on the first post-reset edge.
- Run mode: `RUN_DIV`=3, `sw_run`=1, `tick_in` every 5 cycles for 30 ticks → exactly 10 `cpu_en` pulses, each one cycle wide, each 1 cycle after every 3rd tick. `step_count`=10.
- Bounce: `btn_step` toggles every tick for 6 ticks, then is held high for 4 ticks (`DEB_SAMPLES`=4) → no pulse during toggling. Exactly one `cpu_en` 2 cycles after the 4th high sample. `state_out` returns to 0.
- Halt priority: in RUN, assert `halt_in` in the same cycle as the terminal tick → no `cpu_en`, `state_out`=3. Deassert `halt_in` → `state_out`=0 next cycle.
- Run drop: `sw_run`=0, synchronized, coinciding with a terminal `tick_in` → no pulse; state goes to IDLE.
- Wrap: `CNT_W`=4, issue 17 single steps → `step_count`=1.

Source files
------------

// File: rtl/step_ctrl_pkg.sv
// Shared definitions for the step controller: the FSM state width and its encoding.
package step_ctrl_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      STEP   = 2'd2,
      HALTED = 2'd3
   } state_e;

endpackage

// File: rtl/debounce_tick.sv
// Step button conditioning: 2-FF synchronizer, tick-sampled debounce shift register,
// debounced level and a one-cycle pulse on its rising edge.
module debounce_tick #(
   parameter int DEB_SAMPLES = 4
) (
   input  logic clock_in,
   input  logic reset_n,
   input  logic tick_in,
   input  logic btn_raw,
   output logic btn_db,
   output logic step_req
);

   logic                   sync1_q;
   logic                   sync2_q;
   logic [DEB_SAMPLES-1:0] shift_q;
   logic [DEB_SAMPLES-1:0] shift_d;
   logic                   btn_db_q;
   logic                   btn_db_d;
   logic                   step_req_q;
   logic                   step_req_d;

   // The level and edge are judged on the post-shift value so the edge appears one cycle after the deciding sample.
   always_comb begin
      shift_d = shift_q;
      if (tick_in) begin
         shift_d = {shift_q[DEB_SAMPLES-2:0], sync2_q};
      end
      btn_db_d = btn_db_q;
      if (&shift_d) begin
         btn_db_d = 1'b1;
      end else if (~|shift_d) begin
         btn_db_d = 1'b0;
      end
      step_req_d = btn_db_d & ~btn_db_q;
   end

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         shift_q    <= '0;
         btn_db_q   <= 1'b0;
         step_req_q <= 1'b0;
      end else begin
         sync1_q    <= btn_raw;
         sync2_q    <= sync1_q;
         shift_q    <= shift_d;
         btn_db_q   <= btn_db_d;
         step_req_q <= step_req_d;
      end
   end

   assign btn_db   = btn_db_q;
   assign step_req = step_req_q;

endmodule

// File: rtl/step_controller.sv
// Turns divider ticks into the CPU advance enable: free-running every RUN_DIV ticks,
// or one enable per debounced step-button press; halt_in always wins.
module step_controller
   import step_ctrl_pkg::*;
#(
   parameter int DEB_SAMPLES = 4,
   parameter int RUN_DIV     = 1,
   parameter int CNT_W       = 16
) (
   input  logic               clock_in,
   input  logic               reset_n,
   input  logic               tick_in,
   input  logic               btn_step,
   input  logic               sw_run,
   input  logic               halt_in,
   output logic               cpu_en,
   output logic [STATE_W-1:0] state_out,
   output logic [CNT_W-1:0]   step_count
);

   localparam logic [7:0] DIV_LAST = 8'(RUN_DIV - 1);

   logic             btn_db;
   logic             step_req;
   logic             run_sync1_q;
   logic             run_sync2_q;
   state_e           state_q;
   state_e           state_d;
   logic [7:0]       div_q;
   logic [7:0]       div_d;
   logic             cpu_en_q;
   logic             cpu_en_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   debounce_tick #(
      .DEB_SAMPLES(DEB_SAMPLES)
   ) u_debounce (
      .clock_in(clock_in),
      .reset_n (reset_n),
      .tick_in (tick_in),
      .btn_raw (btn_step),
      .btn_db  (btn_db),
      .step_req(step_req)
   );

   // The enable is decided here and registered, so STEP shows cpu_en in the same cycle it is entered.
   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      cpu_en_d = 1'b0;
      count_d  = cpu_en_q ? count_q + 1'b1 : count_q;
      if (halt_in) begin
         state_d = HALTED;
      end else begin
         case (state_q)
            IDLE: begin
               if (run_sync2_q) begin
                  state_d = RUN;
                  div_d   = '0;
               end else if (step_req && btn_db) begin
                  state_d  = STEP;
                  cpu_en_d = 1'b1;
               end
            end
            RUN: begin
               if (!run_sync2_q) begin
                  state_d = IDLE;
               end else if (tick_in) begin
                  if (div_q == DIV_LAST) begin
                     div_d    = '0;
                     cpu_en_d = 1'b1;
                  end else begin
                     div_d = div_q + 1'b1;
                  end
               end
            end
            STEP:    state_d = IDLE;
            HALTED:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         run_sync1_q <= 1'b0;
         run_sync2_q <= 1'b0;
         state_q     <= IDLE;
         div_q       <= '0;
         cpu_en_q    <= 1'b0;
         count_q     <= '0;
      end else begin
         run_sync1_q <= sw_run;
         run_sync2_q <= run_sync1_q;
         state_q     <= state_d;
         div_q       <= div_d;
         cpu_en_q    <= cpu_en_d;
         count_q     <= count_d;
      end
   end

   assign cpu_en     = cpu_en_q;
   assign state_out  = state_q;
   assign step_count = count_q;

endmodule
